// File: rtl/bfm_sink_stream_if_if.sv
`default_nettype none
// ============================================================================
// Module   : bfm_sink_stream_if_if
// Desc     : 16-bit AXI4-Stream image bus (tuser = SOF, tlast = EOL) with
//            master (source) and slave (sink) views.
// Revision : 1.0 - initial release
// ============================================================================
interface bfm_sink_stream_if_if #(
  parameter int DATA_W = 16
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tuser;
  logic              tlast;

  // Source side drives the beat and samples the sink's ready.
  modport master (output tvalid, tdata, tuser, tlast, input tready);
  // Sink side samples the beat and drives ready.
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/bfm_sink_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : bfm_sink_stream_if
// Desc     : Image-stream sink/checker. Generates a programmable tready
//            pattern, checks SOF/EOL geometry against IMG_WIDTH/IMG_HEIGHT,
//            checks that pixel data increments by one per beat, and counts
//            completed frames and error cycles.
//            Optional macro BFM_SINK_CHECKSUM_EN adds the frame_sum output
//            (32-bit wrap-around sum of the pixel data of each frame).
// Revision : 1.0 - initial release
// ============================================================================
module bfm_sink_stream_if #(
  parameter int          DATA_W    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  wire                 clk,
  input  wire                 rst_n,
  input  wire  [15:0]         IMG_WIDTH,
  input  wire  [15:0]         IMG_HEIGHT,
  input  wire  [1:0]          READY_MODE,
  bfm_sink_stream_if_if.slave s_axis,
  output logic [15:0]         frame_cnt,
  output logic                frame_done,
  output logic                err_sof,
  output logic                err_eol,
  output logic                err_data,
  output logic [15:0]         err_cnt
`ifdef BFM_SINK_CHECKSUM_EN
  ,
  output logic [31:0]         frame_sum
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  localparam logic [15:0] c_ERR_MAX = 16'hFFFF;

  state_t            r_state;
  logic              r_ready;
  logic [15:0]       r_lfsr;
  logic [15:0]       r_col;
  logic [15:0]       r_row;
  logic [DATA_W-1:0] r_ref;
  logic              r_ref_valid;

  logic              w_beat;
  logic              w_last_col;
  logic              w_last_row;
  logic [DATA_W-1:0] w_ref_next;
  logic              w_sof_start;
  logic              w_frame_end;
  logic              w_err_sof;
  logic              w_err_eol;
  logic              w_err_data;
  logic              w_lfsr_fb;

  assign s_axis.tready = r_ready;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Per-beat classification: position, SOF/EOL/data errors, frame start/end.
  always_comb begin
    w_beat      = s_axis.tvalid & r_ready;
    // >= rather than == so a width/height change mid-frame cannot strand the counters.
    w_last_col  = (r_col >= (IMG_WIDTH - 16'd1));
    w_last_row  = (r_row >= (IMG_HEIGHT - 16'd1));
    w_ref_next  = r_ref + DATA_W'(1);
    w_err_data  = w_beat & r_ref_valid & (s_axis.tdata != w_ref_next);
    w_sof_start = 1'b0;
    w_frame_end = 1'b0;
    w_err_sof   = 1'b0;
    w_err_eol   = 1'b0;
    if (w_beat) begin
      if (s_axis.tuser) begin
        // Any SOF beat is taken as pixel (0,0); with width >= 2 that pixel never ends a line.
        w_sof_start = 1'b1;
        w_err_eol   = s_axis.tlast;
        if (r_state == ST_RECV && (r_col != 16'd0 || r_row != 16'd0)) begin
          w_err_sof = 1'b1;
        end
      end else if (r_state == ST_IDLE) begin
        // Beat outside a frame without SOF: flagged and discarded.
        w_err_sof = 1'b1;
      end else begin
        w_err_eol   = (s_axis.tlast != w_last_col);
        w_frame_end = w_last_col & w_last_row;
      end
    end
  end

  // Backpressure generator: tready for the next cycle follows the current READY_MODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= LFSR_SEED;
      r_ready <= 1'b0;
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      case (READY_MODE)
        2'd0:    r_ready <= 1'b1;
        2'd1:    r_ready <= ~r_ready;
        2'd2:    r_ready <= r_lfsr[0];
        default: r_ready <= 1'b0;
      endcase
    end
  end

  // Frame FSM with position counters, data reference and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_col       <= 16'd0;
      r_row       <= 16'd0;
      r_ref       <= '0;
      r_ref_valid <= 1'b0;
      frame_cnt   <= 16'd0;
      frame_done  <= 1'b0;
      err_sof     <= 1'b0;
      err_eol     <= 1'b0;
      err_data    <= 1'b0;
      err_cnt     <= 16'd0;
    end else begin
      frame_done <= w_frame_end;
      err_sof    <= w_err_sof;
      err_eol    <= w_err_eol;
      err_data   <= w_err_data;

      // The reference tracks every accepted beat, including errored and discarded ones.
      if (w_beat) begin
        r_ref       <= s_axis.tdata;
        r_ref_valid <= 1'b1;
      end

      if ((w_err_sof | w_err_eol | w_err_data) && (err_cnt != c_ERR_MAX)) begin
        err_cnt <= err_cnt + 16'd1;
      end

      if (w_frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (w_sof_start) begin
        r_state <= ST_RECV;
        r_col   <= 16'd1;
        r_row   <= 16'd0;
      end else if (w_beat && r_state == ST_RECV) begin
        if (w_frame_end) begin
          r_state <= ST_IDLE;
          r_col   <= 16'd0;
          r_row   <= 16'd0;
        end else if (w_last_col) begin
          r_col <= 16'd0;
          r_row <= r_row + 16'd1;
        end else begin
          r_col <= r_col + 16'd1;
        end
      end
    end
  end

`ifdef BFM_SINK_CHECKSUM_EN
  logic [31:0] r_acc;
  logic [31:0] w_tdata_ext;

  assign w_tdata_ext = 32'(s_axis.tdata);

  // Running frame checksum; the total is published together with frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= 32'd0;
      frame_sum <= 32'd0;
    end else begin
      if (w_sof_start) begin
        r_acc <= w_tdata_ext;
      end else if (w_beat && r_state == ST_RECV) begin
        r_acc <= r_acc + w_tdata_ext;
      end
      if (w_frame_end) begin
        frame_sum <= r_acc + w_tdata_ext;
      end
    end
  end
`endif

endmodule
`default_nettype wire
